// File: rtl/store_buffer.sv
// Posted-store queue between MEM and the data memory: opcode-to-byte-enable
// conversion, misalign rejection, in-order drain and load-hazard stall.

module sb_entry_match #(
    parameter int PTR_W = 2,
    parameter int IDX   = 0
) (
    input  logic [PTR_W-1:0] head,
    input  logic [PTR_W:0]   count,
    input  logic [29:0]      entry_word,
    input  logic [29:0]      ld_word,
    output logic             hit
);
    logic [PTR_W-1:0] offset;

    // An entry is live when its distance from head is inside the occupancy.
    assign offset = PTR_W'(IDX) - head;
    assign hit    = ({1'b0, offset} < count) && (entry_word == ld_word);
endmodule

module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        st_valid,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [31:0] st_pc,
    output logic        st_ready,
    output logic        st_misalign,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    input  logic        drain_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_pc,
    output logic        sb_empty
);
    logic [31:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [3:0]  be_q   [DEPTH];
    logic [31:0] pc_q   [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    logic             full, enq, deq;
    logic [3:0]       be;
    logic [DEPTH-1:0] hit;
    logic             unused_ld_lsb;

    always_comb begin
        be = 4'b0000;
        case (st_op)
            2'b00:   be = 4'b1111;
            2'b01:   be = 4'b0001;
            2'b10:   be = 4'b0011;
            default: be = 4'b0000;
        endcase
    end

    assign full        = (count == (PTR_W+1)'(DEPTH));
    assign st_ready    = !full;
    assign sb_empty    = (count == '0);
    assign st_misalign = st_valid && ((st_op == 2'b00 && st_addr[1:0] != 2'b00) ||
                                      (st_op == 2'b10 && st_addr[0]));
    assign enq         = st_valid && !full && !st_misalign && (st_op != 2'b11);
    assign deq         = !sb_empty && drain_en;
    assign mem_we      = deq;

    assign mem_addr = sb_empty ? 32'h0 : addr_q[head];
    assign mem_din  = sb_empty ? 32'h0 : data_q[head];
    assign mem_be   = sb_empty ? 4'h0  : be_q[head];
    assign mem_pc   = sb_empty ? 32'h0 : pc_q[head];

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_match
            sb_entry_match #(.PTR_W(PTR_W), .IDX(i)) u_match (
                .head       (head),
                .count      (count),
                .entry_word (addr_q[i][31:2]),
                .ld_word    (ld_addr[31:2]),
                .hit        (hit[i])
            );
        end
    endgenerate

    // A store entering this cycle also blocks a load of the same word.
    assign ld_stall = ld_valid && ((|hit) || (enq && st_addr[31:2] == ld_addr[31:2]));
    assign unused_ld_lsb = ^ld_addr[1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            addr_q[tail] <= st_addr;
            data_q[tail] <= st_data;
            be_q[tail]   <= be;
            pc_q[tail]   <= st_pc;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic checked
// against a queue-based model of the posted-store buffer.

module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        st_valid = 1'b0;
    logic [1:0]  st_op = 2'b00;
    logic [31:0] st_addr = '0, st_data = '0, st_pc = '0;
    logic        st_ready, st_misalign;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        ld_stall;
    logic        drain_en = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr, mem_din, mem_pc;
    logic [3:0]  mem_be;
    logic        sb_empty;

    store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
        .st_ready(st_ready), .st_misalign(st_misalign),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .drain_en(drain_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
        .mem_pc(mem_pc), .sb_empty(sb_empty)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic is_mis(input logic v, input logic [1:0] op, input logic [31:0] a);
        return v && ((op == 2'b00 && a[1:0] != 2'b00) || (op == 2'b10 && a[0]));
    endfunction

    function automatic logic [3:0] be_of(input logic [1:0] op);
        case (op)
            2'b00:   return 4'b1111;
            2'b01:   return 4'b0001;
            2'b10:   return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    // Check every output at the negedge against the model, then advance the model at posedge.
    task automatic step();
        logic e_mis, e_enq, e_deq, e_stall;
        ent_t h, n;
        @(negedge clock);
        e_mis   = is_mis(st_valid, st_op, st_addr);
        e_enq   = st_valid && (q.size() != DEPTH) && !e_mis && (st_op != 2'b11);
        e_deq   = (q.size() != 0) && drain_en;
        e_stall = 1'b0;
        if (ld_valid) begin
            foreach (q[k]) if (q[k].addr[31:2] == ld_addr[31:2]) e_stall = 1'b1;
            if (e_enq && st_addr[31:2] == ld_addr[31:2]) e_stall = 1'b1;
        end
        h = (q.size() != 0) ? q[0] : '0;
        chk("st_ready", 32'(st_ready), 32'(q.size() != DEPTH));
        chk("st_misalign", 32'(st_misalign), 32'(e_mis));
        chk("ld_stall", 32'(ld_stall), 32'(e_stall));
        chk("mem_we", 32'(mem_we), 32'(e_deq));
        chk("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
        chk("mem_addr", mem_addr, h.addr);
        chk("mem_din", mem_din, h.data);
        chk("mem_be", 32'(mem_be), 32'(h.be));
        chk("mem_pc", mem_pc, h.pc);
        @(posedge clock);
        if (e_deq) void'(q.pop_front());
        if (e_enq) begin
            n.addr = st_addr; n.data = st_data; n.be = be_of(st_op); n.pc = st_pc;
            q.push_back(n);
        end
        #1;
    endtask

    task automatic set_st(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] pc);
        st_valid = 1'b1; st_op = op; st_addr = a; st_data = d; st_pc = pc;
    endtask

    initial begin
        #1;
        chk("rst_sb_empty", 32'(sb_empty), 32'd1);
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // single sw, one cycle queued, then written
        drain_en = 1'b1;
        set_st(2'b00, 32'h10, 32'hDEADBEEF, 32'h3000);
        step();
        st_valid = 1'b0;
        chk("sw_we", 32'(mem_we), 32'd1);
        chk("sw_addr", mem_addr, 32'h10);
        chk("sw_be", 32'(mem_be), 32'hF);
        chk("sw_pc", mem_pc, 32'h3000);
        chk("sw_din", mem_din, 32'hDEADBEEF);
        step();
        chk("sw_empty_after", 32'(sb_empty), 32'd1);

        // byte-enable encoding
        set_st(2'b10, 32'h22, 32'h1234, 32'h3004);
        step();
        st_valid = 1'b0;
        chk("sh_be", 32'(mem_be), 32'h3);
        chk("sh_addr", mem_addr, 32'h22);
        step();
        set_st(2'b01, 32'h03, 32'hAB, 32'h3008);
        step();
        st_valid = 1'b0;
        chk("sb_be", 32'(mem_be), 32'h1);
        chk("sb_addr", mem_addr, 32'h03);
        step();

        // misaligned sw / sh are dropped
        set_st(2'b00, 32'h06, 32'h1, 32'h300C);
        #1 chk("mis_sw", 32'(st_misalign), 32'd1);
        step();
        st_valid = 1'b0;
        chk("mis_sw_empty", 32'(sb_empty), 32'd1);
        chk("mis_sw_we", 32'(mem_we), 32'd0);
        set_st(2'b10, 32'h05, 32'h2, 32'h3010);
        #1 chk("mis_sh", 32'(st_misalign), 32'd1);
        step();
        st_valid = 1'b0;
        chk("mis_sh_empty", 32'(sb_empty), 32'd1);
        step();

        // fill with drain off, hold a fifth, then drain in order
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_st(2'b00, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 32'h4000 + 32'(4 * i));
            step();
        end
        set_st(2'b00, 32'h110, 32'hA004, 32'h4010);
        chk("full_ready", 32'(st_ready), 32'd0);
        step();
        drain_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("drain_order", mem_addr, 32'h100 + 32'(4 * k));
            if (k == 0) chk("held_ready", 32'(st_ready), 32'd0);
            if (k == 1) chk("accept_ready", 32'(st_ready), 32'd1);
            step();
            if (k == 1) st_valid = 1'b0;
        end
        chk("wrap_empty", 32'(sb_empty), 32'd1);

        // load hazard on a pending word
        drain_en = 1'b0;
        set_st(2'b00, 32'h40, 32'h5555, 32'h5000);
        step();
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr = 32'h42;
        #1 chk("hz_same_word", 32'(ld_stall), 32'd1);
        ld_addr = 32'h44;
        #1 chk("hz_next_word", 32'(ld_stall), 32'd0);
        ld_addr = 32'h42;
        drain_en = 1'b1;
        #1 chk("hz_before_drain", 32'(ld_stall), 32'd1);
        step();
        chk("hz_after_drain", 32'(ld_stall), 32'd0);
        ld_valid = 1'b0;
        step();

        // reset while draining discards everything
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_st(2'b00, 32'h200 + 32'(4 * i), 32'hB000 + 32'(i), 32'h6000);
            step();
        end
        st_valid = 1'b0;
        drain_en = 1'b1;
        #1 chk("pre_rst_we", 32'(mem_we), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_empty", 32'(sb_empty), 32'd1);
        q.delete();
        #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            st_valid = ($urandom_range(0, 99) < 60);
            st_op    = 2'($urandom_range(0, 3));
            st_addr  = 32'($urandom_range(0, 31));
            st_data  = $urandom;
            st_pc    = $urandom;
            ld_valid = ($urandom_range(0, 1) == 1);
            ld_addr  = 32'($urandom_range(0, 31));
            drain_en = ($urandom_range(0, 99) < 55);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
